// File: rtl/br_resolve_upd_pkg.sv
// Shared definitions for the branch resolve / predictor-update slice.
// Holds the default BTB index width, update-entry field widths, the
// flush-counter width and the resolve FSM state encoding.
package br_resolve_upd_pkg;

    localparam int unsigned BTB_IDX_W   = 6;
    localparam int unsigned HIT_W       = 1;
    localparam int unsigned TGT_W       = 32;
    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Width of one queued BTB training entry: {hitted, idx, target}.
    function automatic int unsigned entry_w(input int unsigned idx_w);
        return HIT_W + idx_w + TGT_W;
    endfunction

endpackage

// File: rtl/br_resolve_upd_if.sv
// Bus between the EX pipe / BTB write port and br_resolve_upd.
//   master : pipe + BTB side (drives EX slot fields and upd_ready)
//   slave  : br_resolve_upd (drives redirect, BTB write fields, counters)
interface br_resolve_upd_if
    import br_resolve_upd_pkg::*;
#(
    parameter int unsigned IDX_W = BTB_IDX_W
);
    logic                 ex_valid;
    logic                 ex_is_br;
    logic [31:0]          ex_pc;
    logic                 ex_pred_taken;
    logic [31:0]          ex_pred_target;
    logic                 ex_taken;
    logic [31:0]          ex_target;
    logic                 upd_ready;

    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 bp_we;
    logic [IDX_W-1:0]     bp_pc_low;
    logic                 bp_hitted;
    logic [31:0]          bp_wtarget;
    logic [IDX_W-1:0]     bp_hit_addr;
    logic [31:0]          br_cnt;
    logic [31:0]          mis_cnt;
    logic [15:0]          drop_cnt;

    modport master (
        output ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_pred_target,
               ex_taken, ex_target, upd_ready,
        input  redirect, redirect_pc, bp_we, bp_pc_low, bp_hitted,
               bp_wtarget, bp_hit_addr, br_cnt, mis_cnt, drop_cnt
    );

    modport slave (
        input  ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_pred_target,
               ex_taken, ex_target, upd_ready,
        output redirect, redirect_pc, bp_we, bp_pc_low, bp_hitted,
               bp_wtarget, bp_hit_addr, br_cnt, mis_cnt, drop_cnt
    );

endinterface

// File: rtl/br_resolve_upd_upd_fifo.sv
// Synchronous FIFO for BTB training entries.
// Ports: clk, rst_n, push/din (write), pop (read), dout (head entry),
// full, empty. A push on a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is ignored by the FIFO.
module upd_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/br_resolve_upd.sv
// Execute-stage branch resolution and BTB/2-bit predictor update.
// Ports: clk, rst_n (async, active-low), bus (slave modport):
//   EX slot inputs ex_* and upd_ready; registered redirect/redirect_pc;
//   BTB write fields bp_* driven from the update-queue head; counters
//   br_cnt, mis_cnt, drop_cnt.
module br_resolve_upd
    import br_resolve_upd_pkg::*;
#(
    parameter int unsigned IDX_W      = BTB_IDX_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FLUSH_CYC  = 2
) (
    input logic         clk,
    input logic         rst_n,
    br_resolve_upd_if.slave bus
);

    typedef struct packed {
        logic             hitted;
        logic [IDX_W-1:0] idx;
        logic [TGT_W-1:0] target;
    } upd_entry_t;

    localparam int unsigned ENTRY_W = entry_w(IDX_W);

    state_t                 state;
    state_t                 state_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;

    logic       res;
    logic       act_taken;
    logic       mispred;
    logic       pop;
    logic       full;
    logic       empty;
    logic       drop;
    upd_entry_t push_entry;
    upd_entry_t head_raw;
    upd_entry_t head;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;
    logic [15:0] drop_cnt;

    // Resolve compare; a predicted-taken non-branch resolves as not taken
    assign res       = bus.ex_valid && (state == RUN) && (bus.ex_is_br || bus.ex_pred_taken);
    assign act_taken = bus.ex_taken && bus.ex_is_br;
    assign mispred   = res && ((bus.ex_pred_taken != act_taken) ||
                               (bus.ex_pred_taken && act_taken &&
                                (bus.ex_pred_target != bus.ex_target)));

    // Queue control: push+pop on a full queue is accepted, not dropped
    assign pop        = !empty && bus.upd_ready;
    assign drop       = res && full && !pop;
    assign push_entry = {act_taken, bus.ex_pc[IDX_W+1:2], bus.ex_target};

    upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    // BTB write port follows the head entry, zeroed while empty
    assign head            = empty ? '0 : head_raw;
    assign bus.bp_we       = pop;
    assign bus.bp_pc_low   = head.idx;
    assign bus.bp_hit_addr = head.idx;
    assign bus.bp_hitted   = head.hitted;
    assign bus.bp_wtarget  = head.target;

    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;
    assign bus.br_cnt      = br_cnt;
    assign bus.mis_cnt     = mis_cnt;
    assign bus.drop_cnt    = drop_cnt;

    // Squash FSM next state; last squashed cycle is the one taking cnt 1->0
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (mispred) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYC);
                end
            end
            FLUSH: begin
                flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                if (flush_cnt == FLUSH_CNT_W'(1)) state_nxt = RUN;
            end
            default: begin
                state_nxt     = RUN;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Redirect pulse and statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            br_cnt      <= '0;
            mis_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            redirect <= mispred;
            if (mispred) redirect_pc <= act_taken ? bus.ex_target : bus.ex_pc + 32'd4;
            if (res && bus.ex_is_br) br_cnt <= br_cnt + 32'd1;
            if (mispred) mis_cnt <= mis_cnt + 32'd1;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_br_resolve_upd.sv
// Directed + random bench for br_resolve_upd against a queue-based model.
module tb_br_resolve_upd;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FLUSH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    br_resolve_upd_if ifc ();

    br_resolve_upd #(
        .IDX_W      (6),
        .FIFO_DEPTH (DEPTH),
        .FLUSH_CYC  (FLUSH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct {
        logic [5:0]  idx;
        logic        hit;
        logic [31:0] tgt;
    } ent_t;

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        q[$];
    int          squash_left;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic [15:0] m_drop;
    logic        m_redir;
    logic [31:0] m_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        squash_left = 0;
        m_br = 0; m_mis = 0; m_drop = 0; m_redir = 0; m_rpc = 0;
    endtask

    // Apply EX slot inputs, then check the combinational BTB write side
    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt,
                         input logic t, input logic [31:0] tgt, input logic rdy);
        ifc.ex_valid = v; ifc.ex_is_br = br; ifc.ex_pc = pc;
        ifc.ex_pred_taken = pt; ifc.ex_pred_target = ptgt;
        ifc.ex_taken = t; ifc.ex_target = tgt; ifc.upd_ready = rdy;
        #1;
        chk("bp_we", 32'(ifc.bp_we), 32'((q.size() > 0) && rdy));
        if (q.size() > 0) begin
            chk("bp_pc_low", 32'(ifc.bp_pc_low), 32'(q[0].idx));
            chk("bp_hit_addr", 32'(ifc.bp_hit_addr), 32'(q[0].idx));
            chk("bp_hitted", 32'(ifc.bp_hitted), 32'(q[0].hit));
            chk("bp_wtarget", ifc.bp_wtarget, q[0].tgt);
        end else begin
            chk("bp_pc_low_empty", 32'(ifc.bp_pc_low), 32'd0);
            chk("bp_wtarget_empty", ifc.bp_wtarget, 32'd0);
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
    endtask

    // Clock edge: advance the model from the spec rules, check registered outputs
    task automatic tick();
        bit   sq, res, act, mis;
        ent_t e;
        @(posedge clk);
        sq  = (squash_left > 0);
        res = ifc.ex_valid && !sq && (ifc.ex_is_br || ifc.ex_pred_taken);
        act = ifc.ex_taken && ifc.ex_is_br;
        mis = res && ((ifc.ex_pred_taken != act) ||
                      (ifc.ex_pred_taken && act && (ifc.ex_pred_target != ifc.ex_target)));
        if ((q.size() > 0) && ifc.upd_ready) void'(q.pop_front());
        if (res) begin
            e.idx = ifc.ex_pc[7:2]; e.hit = act; e.tgt = ifc.ex_target;
            if (q.size() < DEPTH) q.push_back(e);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (res && ifc.ex_is_br) m_br++;
        if (mis) m_mis++;
        m_redir = mis;
        if (mis) m_rpc = act ? ifc.ex_target : ifc.ex_pc + 32'd4;
        if (sq) squash_left--;
        if (mis) squash_left = FLUSH;
        #1;
        chk("redirect", 32'(ifc.redirect), 32'(m_redir));
        if (m_redir) chk("redirect_pc", ifc.redirect_pc, m_rpc);
        chk("br_cnt", ifc.br_cnt, m_br);
        chk("mis_cnt", ifc.mis_cnt, m_mis);
        chk("drop_cnt", 32'(ifc.drop_cnt), 32'(m_drop));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.ex_valid = 0; ifc.ex_is_br = 0; ifc.ex_pc = 0; ifc.ex_pred_taken = 0;
        ifc.ex_pred_target = 0; ifc.ex_taken = 0; ifc.ex_target = 0; ifc.upd_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_redirect", 32'(ifc.redirect), 32'd0);
        chk("rst_redirect_pc", ifc.redirect_pc, 32'd0);
        chk("rst_bp_we", 32'(ifc.bp_we), 32'd0);
        chk("rst_br_cnt", ifc.br_cnt, 32'd0);
        chk("rst_drop_cnt", 32'(ifc.drop_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct predict
        drive(1, 1, 32'h1C000010, 1, 32'h1C000100, 1, 32'h1C000100, 1);
        tick();
        chk("cp_redirect", 32'(ifc.redirect), 32'd0);
        chk("cp_br_cnt", ifc.br_cnt, 32'd1);
        idle(1);
        chk("cp_bp_we", 32'(ifc.bp_we), 32'd1);
        chk("cp_idx", 32'(ifc.bp_pc_low), 32'd4);
        chk("cp_hitted", 32'(ifc.bp_hitted), 32'd1);
        chk("cp_target", ifc.bp_wtarget, 32'h1C000100);
        tick();

        // Direction mispredict, then two squashed valid branches
        drive(1, 1, 32'h1C000020, 0, 32'd0, 1, 32'h1C000200, 1);
        tick();
        chk("dm_redirect", 32'(ifc.redirect), 32'd1);
        chk("dm_redirect_pc", ifc.redirect_pc, 32'h1C000200);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h1C000030, 0, 32'd0, 1, 32'h1C000500, 1);
            tick();
        end
        chk("dm_br_cnt", ifc.br_cnt, 32'd2);
        chk("dm_mis_cnt", ifc.mis_cnt, 32'd1);
        idle(1);
        chk("dm_no_update", 32'(ifc.bp_we), 32'd0);
        tick();

        // Target mispredict
        drive(1, 1, 32'h1C000050, 1, 32'h1C000300, 1, 32'h1C000400, 1);
        tick();
        chk("tm_redirect_pc", ifc.redirect_pc, 32'h1C000400);
        idle(1); tick();
        idle(1); tick();

        // BTB alias: non-branch predicted taken
        drive(1, 0, 32'h1C000040, 1, 32'h1C000080, 0, 32'h1C000080, 1);
        tick();
        chk("al_redirect_pc", ifc.redirect_pc, 32'h1C000044);
        idle(1);
        chk("al_idx", 32'(ifc.bp_pc_low), 32'd16);
        chk("al_hitted", 32'(ifc.bp_hitted), 32'd0);
        tick();
        idle(1); tick();

        // Backpressure: 5 pushes into a 4-deep queue
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h1C000080 + 32'(4 * i), 1, 32'h1C001000, 1, 32'h1C001000, 0);
            tick();
        end
        chk("bp_drop_cnt", 32'(ifc.drop_cnt), 32'd1);
        idle(1);
        chk("bp_first_idx", 32'(ifc.bp_pc_low), 32'd32);
        tick();
        for (int i = 0; i < 3; i++) begin idle(1); tick(); end
        idle(1);
        chk("bp_drained", 32'(ifc.bp_we), 32'd0);
        tick();

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h1C0000C0 + 32'(4 * i), 0, 32'd0, 0, 32'h1C002000, 0);
            tick();
        end
        drive(1, 1, 32'h1C0000D0, 0, 32'd0, 0, 32'h1C003000, 1);
        tick();
        chk("fp_drop_cnt", 32'(ifc.drop_cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin idle(1); tick(); end

        // Async reset mid-drain with a redirect pending
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h1C000010 + 32'(4 * i), 0, 32'd0, 0, 32'h1C004000, 0);
            tick();
        end
        drive(1, 1, 32'h1C000020, 0, 32'd0, 1, 32'h1C005000, 0);
        tick();
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_bp_we", 32'(ifc.bp_we), 32'd0);
        chk("ar_redirect", 32'(ifc.redirect), 32'd0);
        chk("ar_br_cnt", ifc.br_cnt, 32'd0);
        chk("ar_mis_cnt", ifc.mis_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("ar_empty", 32'(ifc.bp_we), 32'd0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        v, br, pt, t, rdy;
            logic [31:0] pc, ptgt, tgt;
            v    = ($urandom_range(0, 9) < 8);
            br   = ($urandom_range(0, 9) < 7);
            pt   = 1'($urandom_range(0, 1));
            t    = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            pc   = 32'h1C000000 + ($urandom & 32'h0000_0FFC);
            ptgt = 32'h1C000000 + 32'($urandom_range(0, 3) << 4);
            tgt  = 32'h1C000000 + 32'($urandom_range(0, 3) << 4);
            drive(v, br, pc, pt, ptgt, t, tgt, rdy);
            tick();
        end
        for (int i = 0; i < 6; i++) begin idle(1); tick(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/br_resolve_upd.md
Name: br_resolve_upd

Overview:
- Execute-stage branch resolution and predictor-update unit; closes the loop on the IF1 BTB/2-bit predictor.
- Compares the prediction carried down the pipe with the actual outcome, then issues a fetch redirect on mispredict.
- Squashes wrong-path resolves while the front end refills.
- Queues BTB training writes in a small FIFO and drains one per cycle into the BTB write port.

Parameters:
- IDX_W, 6, BTB index width; index = pc[IDX_W+1:2].
- FIFO_DEPTH, 4, update-queue entries (power of two).
- FLUSH_CYC, 2, cycles of wrong-path squash after a redirect (1..7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ex_valid  in  1  EX slot holds a valid instruction this cycle.
- ex_is_br  in  1  instruction is a branch/jump.
- ex_pc  in  32  instruction PC.
- ex_pred_taken  in  1  prediction made in IF1 (branch output, piped).
- ex_pred_target  in  32  predicted target (target output, piped).
- ex_taken  in  1  actual outcome.
- ex_target  in  32  actual target.
- upd_ready  in  1  BTB write port free this cycle.
- redirect  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  new fetch PC, valid with redirect.
- bp_we  out  1  BTB write enable.
- bp_pc_low  out  IDX_W  BTB index to write.
- bp_hitted  out  1  outcome bit shifted into the 2-bit history.
- bp_wtarget  out  32  target to store.
- bp_hit_addr  out  IDX_W  target-read index; always equals bp_pc_low.
- br_cnt  out  32  resolved-branch counter.
- mis_cnt  out  32  mispredict counter.
- drop_cnt  out  16  updates dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, FIFO empty, FSM in RUN, all counters 0.
  - Reset mid-drain discards queued updates.
- Resolve condition: res = ex_valid && state==RUN && (ex_is_br || ex_pred_taken).
- Mispredict when res and any of:
  - ex_pred_taken != ex_taken, or
  - ex_pred_taken && ex_taken && ex_pred_target != ex_target.
  - A non-branch with ex_pred_taken=1 (BTB alias) is a mispredict treated as not taken.
- Redirect:
  - Registered, latency 1: redirect=1 in the cycle after a mispredicting res, for exactly one cycle.
  - redirect_pc = ex_taken&&ex_is_br ? ex_target : ex_pc+4, with 32-bit wrap.
- FSM, 2 states:
  - RUN -> FLUSH on a mispredict; load flush counter with FLUSH_CYC.
  - FLUSH: ex_valid is ignored (no resolve, no update, no count); counter decrements each cycle; -> RUN when the counter reaches 1.
  - The cycle that decrements the counter to 0 is the last squashed cycle.
- Update push on every res:
  - Entry {idx=ex_pc[IDX_W+1:2], hitted=ex_taken&&ex_is_br, target=ex_target}.
  - Target is stored even when hitted=0.
- Drain:
  - When FIFO non-empty and upd_ready: bp_we=1 that cycle, combinationally from the head entry.
  - Pop at the clock edge. bp_pc_low/bp_hit_addr/bp_hitted/bp_wtarget show the head entry and are 0 when empty.
- Full FIFO:
  - A push is dropped and drop_cnt increments (saturating at 16'hFFFF).
  - Push and pop in the same cycle on a full FIFO is accepted; no drop.
- Empty FIFO: a push in the same cycle is not bypassed; bp_we rises the next cycle at the earliest.
- Counters:
  - br_cnt increments on each res with ex_is_br.
  - mis_cnt increments on each mispredict.
  - Both wrap at 2^32.
- Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.

Decomposition:
- Shared defs package: IDX_W default, update-entry field widths (1+IDX_W+32), FSM state encodings RUN/FLUSH.
- One sub-module: upd_fifo, a synchronous FIFO with push/pop/full/empty, parameterised by width and depth.
- Resolve compare, FSM and counters stay in br_resolve_upd.

Test Plan:
- Correct predict: pc=0x1C000010, pred_taken=1, taken=1, both targets 0x1C000100 -> no redirect; bp_we next cycle with idx=4, hitted=1, target=0x1C000100; br_cnt=1, mis_cnt=0.
- Direction mispredict: pc=0x1C000020, pred_taken=0, taken=1, target 0x1C000200 -> redirect pulse one cycle later, redirect_pc=0x1C000200; with FLUSH_CYC=2 the ex_valid in the next 2 cycles produces no updates or counts; mis_cnt=1.
- Target mispredict and alias:
  - pred 0x1C000300 vs actual 0x1C000400 -> redirect_pc=0x1C000400.
  - Non-branch at 0x1C000040 with pred_taken=1 -> redirect_pc=0x1C000044, update idx=16, hitted=0.
- Backpressure: upd_ready=0, 5 correct-predict branches -> 4 queued, drop_cnt=1; raise upd_ready -> 4 consecutive bp_we in FIFO order, then bp_we=0.
- Full push+pop: FIFO full, upd_ready=1 and a new branch in the same cycle -> no drop; the count stays 4.
- Async reset during drain: rst_n low mid-cycle -> bp_we, redirect and counters go 0 immediately; after release the FIFO is empty.
